// File: rtl/wrf_rx_sink.sv
// ---------------------------------------------------------------------------
// wrf_rx_sink
//   Receive sink for a pipelined fabric stream. Each frame (snk_cyc_i envelope)
//   starts with a status word carrying the match class and an error flag,
//   followed by data words. Data words pass through a one-word hold register
//   so that the last word of a frame can be tagged with eof when the envelope
//   closes, then go into a first-word-fall-through output FIFO.
//
// Ports
//   clk_sys_i      system clock
//   rst_n_i        asynchronous reset, active-high
//   snk_cyc_i      fabric cycle (frame envelope)
//   snk_stb_i      fabric strobe
//   snk_adr_i[1:0] word type: 00 data, 01 OOB, 10 status, 11 user
//   snk_dat_i[15:0] fabric word
//   snk_sel_i[1:0] byte select
//   snk_ack_o      acknowledge, one cycle after each accepted word
//   snk_stall_o    back-pressure (FIFO almost full)
//   snk_err_o      one-cycle pulse: data word arrived before status
//   src_data_o/src_sel_o/src_sof_o/src_eof_o/src_err_o/src_valid_o
//                  FWFT output word; popped on src_valid_o & src_ready_i
//   src_ready_i    downstream ready
//   class_o[7:0]   match class of current frame
//   frames_ok_o    good-frame counter (wraps)
//   frames_err_o   bad-frame counter (wraps)
// ---------------------------------------------------------------------------
module wrf_rx_sink #(
  parameter int g_fifo_depth = 8
) (
  input  logic        clk_sys_i,
  input  logic        rst_n_i,
  input  logic        snk_cyc_i,
  input  logic        snk_stb_i,
  input  logic [1:0]  snk_adr_i,
  input  logic [15:0] snk_dat_i,
  input  logic [1:0]  snk_sel_i,
  output logic        snk_ack_o,
  output logic        snk_stall_o,
  output logic        snk_err_o,
  output logic [15:0] src_data_o,
  output logic [1:0]  src_sel_o,
  output logic        src_sof_o,
  output logic        src_eof_o,
  output logic        src_err_o,
  output logic        src_valid_o,
  input  logic        src_ready_i,
  output logic [7:0]  class_o,
  output logic [15:0] frames_ok_o,
  output logic [15:0] frames_err_o
);

  localparam int DATA_W = 16;
  localparam int AW     = $clog2(g_fifo_depth);
  localparam int CW     = AW + 1;
  // FIFO entry: {sof, eof, err, sel[1:0], data}
  localparam int FW     = DATA_W + 5;

  localparam logic [1:0] ADR_DATA   = 2'b00;
  localparam logic [1:0] ADR_STATUS = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEADER  = 2'd1,
    S_PAYLOAD = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_cyc_d;
  logic                r_ack;
  logic                r_err_pulse;
  logic                r_bad;
  logic [7:0]          r_class;
  logic [15:0]         r_frames_ok;
  logic [15:0]         r_frames_err;

  logic                r_hold_vld_p0;
  logic [DATA_W-1:0]   r_hold_dat_p0;
  logic [1:0]          r_hold_sel_p0;
  logic                r_hold_sof_p0;

  logic [FW-1:0]       r_mem [g_fifo_depth];
  logic [AW-1:0]       r_wp;
  logic [AW-1:0]       r_rp;
  logic [CW-1:0]       r_cnt;

  logic                w_fall;
  logic                w_stall;
  logic                w_acc;
  logic                w_is_data;
  logic                w_is_stat;
  logic                w_in_hdr;
  logic                w_frame_end;
  logic                w_hdr_stat;
  logic                w_hdr_err;
  logic                w_push_mid;
  logic                w_flush;
  logic                w_push;
  logic [FW-1:0]       w_push_word;
  logic                w_valid;
  logic                w_pop;
  logic                w_full;
  logic                w_wr;
  logic [FW-1:0]       w_rd_word;

  // Handshake and envelope decode
  assign w_fall    = ~snk_cyc_i & r_cyc_d;
  // One slot stays free so the eof flush can always be written.
  assign w_stall   = (r_cnt >= CW'(g_fifo_depth - 1));
  assign w_acc     = snk_cyc_i & snk_stb_i & ~w_stall;
  assign w_is_data = w_acc & (snk_adr_i == ADR_DATA);
  assign w_is_stat = w_acc & (snk_adr_i == ADR_STATUS);

  // FSM: state register
  always_ff @(posedge clk_sys_i or posedge rst_n_i) begin
    if (rst_n_i) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM: next state. A word accepted in IDLE is the first word of a frame
  // whose cyc rose in this same cycle, so it is handled as a header word.
  always_comb begin
    w_state_nxt = r_state;
    if (w_fall) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hdr_stat | w_is_data) w_state_nxt = S_PAYLOAD;
          else if (snk_cyc_i)         w_state_nxt = S_HEADER;
        end
        S_HEADER: begin
          if (w_hdr_stat | w_is_data) w_state_nxt = S_PAYLOAD;
        end
        default: ;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    w_in_hdr    = 1'b0;
    w_frame_end = 1'b0;
    case (r_state)
      S_IDLE:    w_in_hdr = 1'b1;
      S_HEADER:  begin
        w_in_hdr    = 1'b1;
        w_frame_end = w_fall;
      end
      S_PAYLOAD: w_frame_end = w_fall;
      default: ;
    endcase
  end

  assign w_hdr_stat = w_is_stat & w_in_hdr;
  assign w_hdr_err  = w_is_data & w_in_hdr;

  // Data and cyc-fall never coincide (data needs cyc high), so at most one
  // push per cycle.
  assign w_push_mid  = w_is_data & r_hold_vld_p0;
  assign w_flush     = w_fall & r_hold_vld_p0;
  assign w_push      = w_push_mid | w_flush;
  assign w_push_word = {r_hold_sof_p0, w_flush, w_flush & r_bad,
                        r_hold_sel_p0, r_hold_dat_p0};

  // Frame control
  always_ff @(posedge clk_sys_i or posedge rst_n_i) begin
    if (rst_n_i) begin
      r_cyc_d       <= 1'b0;
      r_ack         <= 1'b0;
      r_err_pulse   <= 1'b0;
      r_bad         <= 1'b0;
      r_class       <= 8'h00;
      r_frames_ok   <= 16'h0000;
      r_frames_err  <= 16'h0000;
      r_hold_vld_p0 <= 1'b0;
    end else begin
      r_cyc_d     <= snk_cyc_i;
      r_ack       <= w_acc;
      r_err_pulse <= w_hdr_err;

      if (w_fall) begin
        r_bad <= 1'b0;
      end else if (w_hdr_stat) begin
        r_bad <= snk_dat_i[1];
      end else if (w_hdr_err) begin
        r_bad <= 1'b1;
      end

      if (w_hdr_stat)     r_class <= snk_dat_i[15:8];
      else if (w_hdr_err) r_class <= 8'h00;

      // A held word at frame end means the frame carried data.
      if (w_frame_end) begin
        if (~r_bad & r_hold_vld_p0) r_frames_ok  <= r_frames_ok + 16'd1;
        else                        r_frames_err <= r_frames_err + 16'd1;
      end

      if (w_fall)         r_hold_vld_p0 <= 1'b0;
      else if (w_is_data) r_hold_vld_p0 <= 1'b1;
    end
  end

  // Stage p0: hold register (data only, qualified by r_hold_vld_p0)
  always_ff @(posedge clk_sys_i) begin
    if (w_is_data) begin
      r_hold_dat_p0 <= snk_dat_i;
      r_hold_sel_p0 <= snk_sel_i;
      r_hold_sof_p0 <= ~r_hold_vld_p0;
    end
  end

  // Stage p1: output FIFO, first-word-fall-through
  assign w_valid   = (r_cnt != '0);
  assign w_full    = (r_cnt == CW'(g_fifo_depth));
  assign w_pop     = w_valid & src_ready_i;
  assign w_wr      = w_push & (~w_full | w_pop);
  assign w_rd_word = r_mem[r_rp];

  always_ff @(posedge clk_sys_i) begin
    if (w_wr) r_mem[r_wp] <= w_push_word;
  end

  always_ff @(posedge clk_sys_i or posedge rst_n_i) begin
    if (rst_n_i) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr)  r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Output fields are forced to zero when no word is presented.
  assign snk_ack_o    = r_ack;
  assign snk_stall_o  = w_stall;
  assign snk_err_o    = r_err_pulse;
  assign src_valid_o  = w_valid;
  assign src_data_o   = w_valid ? w_rd_word[DATA_W-1:0]        : '0;
  assign src_sel_o    = w_valid ? w_rd_word[DATA_W+1:DATA_W]   : 2'b00;
  assign src_err_o    = w_valid & w_rd_word[DATA_W+2];
  assign src_eof_o    = w_valid & w_rd_word[DATA_W+3];
  assign src_sof_o    = w_valid & w_rd_word[DATA_W+4];
  assign class_o      = r_class;
  assign frames_ok_o  = r_frames_ok;
  assign frames_err_o = r_frames_err;

endmodule

// File: tb/tb_wrf_rx_sink.sv
// ---------------------------------------------------------------------------
// tb_wrf_rx_sink
//   Scoreboard bench for wrf_rx_sink. Frames are built as word lists; a
//   frame-level reference model derives the expected output words and the
//   expected class/counter/error-pulse results before the frame is driven.
//   A negedge monitor pops the expected queue on each delivered word and also
//   checks the ack timing every cycle.
// ---------------------------------------------------------------------------
module tb_wrf_rx_sink;

  logic        clk_sys_i = 1'b0;
  logic        rst_n_i   = 1'b1;
  logic        snk_cyc_i = 1'b0;
  logic        snk_stb_i = 1'b0;
  logic [1:0]  snk_adr_i = 2'b00;
  logic [15:0] snk_dat_i = 16'h0000;
  logic [1:0]  snk_sel_i = 2'b00;
  logic        snk_ack_o;
  logic        snk_stall_o;
  logic        snk_err_o;
  logic [15:0] src_data_o;
  logic [1:0]  src_sel_o;
  logic        src_sof_o;
  logic        src_eof_o;
  logic        src_err_o;
  logic        src_valid_o;
  logic        src_ready_i = 1'b0;
  logic [7:0]  class_o;
  logic [15:0] frames_ok_o;
  logic [15:0] frames_err_o;

  wrf_rx_sink #(.g_fifo_depth(8)) dut (
    .clk_sys_i   (clk_sys_i),
    .rst_n_i     (rst_n_i),
    .snk_cyc_i   (snk_cyc_i),
    .snk_stb_i   (snk_stb_i),
    .snk_adr_i   (snk_adr_i),
    .snk_dat_i   (snk_dat_i),
    .snk_sel_i   (snk_sel_i),
    .snk_ack_o   (snk_ack_o),
    .snk_stall_o (snk_stall_o),
    .snk_err_o   (snk_err_o),
    .src_data_o  (src_data_o),
    .src_sel_o   (src_sel_o),
    .src_sof_o   (src_sof_o),
    .src_eof_o   (src_eof_o),
    .src_err_o   (src_err_o),
    .src_valid_o (src_valid_o),
    .src_ready_i (src_ready_i),
    .class_o     (class_o),
    .frames_ok_o (frames_ok_o),
    .frames_err_o(frames_err_o)
  );

  always #5 clk_sys_i = ~clk_sys_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected output words: {sof, eof, err, sel[1:0], data[15:0]}
  logic [20:0] exp_q[$];
  // Frame under construction: {adr[1:0], sel[1:0], dat[15:0]}
  logic [19:0] fr[$];

  logic [15:0] m_ok    = 16'h0000;
  logic [15:0] m_err   = 16'h0000;
  logic [7:0]  m_class = 8'h00;
  int          exp_err_pulses = 0;

  int  accepted   = 0;
  int  ack_cnt    = 0;
  int  err_seen   = 0;
  bit  prev_acc   = 1'b0;
  bit  prev_err   = 1'b0;
  bit  rdy_rand   = 1'b0;
  bit  rdy_force  = 1'b1;
  bit  send_busy  = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] mk(input logic [1:0] adr,
                                     input logic [1:0] sel,
                                     input logic [15:0] dat);
    return {adr, sel, dat};
  endfunction

  // Frame-level reference: first of {status, data} decides the header; data
  // words in order become the payload; everything else is dropped.
  task automatic model_frame(output int pulses);
    bit          seen;
    bit          bad;
    logic [20:0] outs[$];
    seen   = 1'b0;
    bad    = 1'b0;
    pulses = 0;
    foreach (fr[i]) begin
      if (fr[i][19:18] == 2'b10 && !seen) begin
        seen    = 1'b1;
        m_class = fr[i][15:8];
        bad     = fr[i][1];
      end else if (fr[i][19:18] == 2'b00) begin
        if (!seen) begin
          seen    = 1'b1;
          bad     = 1'b1;
          m_class = 8'h00;
          pulses  = 1;
        end
        outs.push_back({3'b000, fr[i][17:0]});
      end
    end
    if (outs.size() > 0) begin
      outs[0][20]              = 1'b1;
      outs[outs.size()-1][19]  = 1'b1;
      outs[outs.size()-1][18]  = bad;
    end
    foreach (outs[i]) exp_q.push_back(outs[i]);
    if (!bad && outs.size() > 0) m_ok  = m_ok + 16'd1;
    else                         m_err = m_err + 16'd1;
    exp_err_pulses += pulses;
  endtask

  task automatic send_word(input logic [19:0] w);
    bit got;
    got       = 1'b0;
    snk_stb_i = 1'b1;
    snk_adr_i = w[19:18];
    snk_sel_i = w[17:16];
    snk_dat_i = w[15:0];
    for (int t = 0; t < 400; t++) begin
      @(negedge clk_sys_i);
      if (!snk_stall_o) begin
        got = 1'b1;
        break;
      end
    end
    if (got) accepted++;
    else     check("stall_timeout", 32'd1, 32'd0);
    @(posedge clk_sys_i); #1;
    snk_stb_i = 1'b0;
  endtask

  task automatic send_frame(input int pre_gap);
    send_busy = 1'b1;
    @(posedge clk_sys_i); #1;
    snk_cyc_i = 1'b1;
    repeat (pre_gap) begin
      @(posedge clk_sys_i); #1;
    end
    foreach (fr[i]) begin
      send_word(fr[i]);
      repeat ($urandom_range(0, 1)) begin
        @(posedge clk_sys_i); #1;
      end
    end
    snk_cyc_i = 1'b0;
    repeat ($urandom_range(1, 3)) begin
      @(posedge clk_sys_i); #1;
    end
    send_busy = 1'b0;
  endtask

  task automatic check_frame_results(input string tag, input int err0,
                                     input int pulses);
    @(negedge clk_sys_i);
    check({tag, "_class"},   class_o,           m_class);
    check({tag, "_ok"},      frames_ok_o,       m_ok);
    check({tag, "_err"},     frames_err_o,      m_err);
    check({tag, "_errpulse"}, err_seen - err0,  pulses);
  endtask

  task automatic run_frame(input string tag, input int pre_gap);
    int e0;
    int p;
    e0 = err_seen;
    model_frame(p);
    send_frame(pre_gap);
    check_frame_results(tag, e0, p);
  endtask

  task automatic drain(input string tag);
    for (int t = 0; t < 1000 && exp_q.size() != 0; t++) @(negedge clk_sys_i);
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk_sys_i);
    check({tag, "_ctl"}, {snk_ack_o, snk_stall_o, snk_err_o, src_valid_o,
                          src_sof_o, src_eof_o, src_err_o}, 0);
    check({tag, "_data"},  {src_sel_o, src_data_o}, 0);
    check({tag, "_class"}, class_o,      0);
    check({tag, "_cnt"},   {frames_ok_o, frames_err_o}, 0);
  endtask

  task automatic gen_random_frame();
    int          kind;
    int          n;
    logic [15:0] s;
    fr.delete();
    kind = $urandom_range(0, 3);
    if (kind != 2) begin
      s    = 16'($urandom);
      s[1] = ($urandom_range(0, 3) == 0);
      fr.push_back(mk(2'b10, 2'b11, s));
    end
    n = (kind == 3) ? 0 : $urandom_range(1, 6);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 4) == 0)
        fr.push_back(mk(2'($urandom_range(1, 3)), 2'b11, 16'($urandom)));
      fr.push_back(mk(2'b00, ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b10,
                      16'($urandom)));
    end
    if (kind == 3 && $urandom_range(0, 1) != 0)
      fr.push_back(mk(2'b01, 2'b11, 16'($urandom)));
  endtask

  // Downstream ready driver
  initial begin
    forever begin
      @(posedge clk_sys_i); #1;
      src_ready_i = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
    end
  end

  // Monitor: ack timing, error pulses, output scoreboard
  always @(negedge clk_sys_i) begin
    logic [20:0] e;
    check("ack_timing", snk_ack_o, prev_acc & ~rst_n_i);
    prev_acc = snk_cyc_i & snk_stb_i & ~snk_stall_o & ~rst_n_i;
    if (snk_ack_o) ack_cnt++;
    if (snk_err_o) begin
      err_seen++;
      check("err_pulse_width", prev_err, 1'b0);
    end
    prev_err = snk_err_o;
    if (src_valid_o && src_ready_i && !rst_n_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {src_sof_o, src_eof_o, src_err_o,
              src_sel_o, src_data_o}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("out_word", {src_sof_o, src_eof_o, src_err_o, src_sel_o,
                           src_data_o}, e);
      end
    end
  end

  initial begin
    int a0;
    int e0;
    int p;

    // Reset state
    repeat (3) @(posedge clk_sys_i);
    check_reset_outputs("reset");
    @(posedge clk_sys_i); #1;
    rst_n_i   = 1'b0;
    rdy_rand  = 1'b0;
    rdy_force = 1'b1;

    // Status 0x0300 + four data words
    fr.delete();
    fr.push_back(mk(2'b10, 2'b11, 16'h0300));
    fr.push_back(mk(2'b00, 2'b11, 16'h1111));
    fr.push_back(mk(2'b00, 2'b11, 16'h2222));
    fr.push_back(mk(2'b00, 2'b11, 16'h3333));
    fr.push_back(mk(2'b00, 2'b11, 16'h4444));
    run_frame("basic", 1);
    drain("basic");

    // Status with error bit
    fr.delete();
    fr.push_back(mk(2'b10, 2'b11, 16'h0002));
    fr.push_back(mk(2'b00, 2'b11, 16'hA5A5));
    fr.push_back(mk(2'b00, 2'b10, 16'h5A00));
    run_frame("errbit", 0);
    drain("errbit");

    // Data before status; the late status is discarded
    fr.delete();
    fr.push_back(mk(2'b00, 2'b11, 16'hBEEF));
    fr.push_back(mk(2'b10, 2'b11, 16'h0900));
    fr.push_back(mk(2'b00, 2'b11, 16'hCAFE));
    run_frame("nostatus", 1);
    drain("nostatus");

    // Status only, with an OOB word
    fr.delete();
    fr.push_back(mk(2'b10, 2'b11, 16'h0500));
    fr.push_back(mk(2'b01, 2'b11, 16'h1234));
    run_frame("statusonly", 0);
    drain("statusonly");

    // Back-pressure: 20 data words with downstream stalled
    rdy_force = 1'b0;
    fr.delete();
    fr.push_back(mk(2'b10, 2'b11, 16'h0700));
    for (int i = 0; i < 20; i++) fr.push_back(mk(2'b00, 2'b11, 16'(16'h0100 + i)));
    e0 = err_seen;
    model_frame(p);
    a0 = accepted;
    fork
      send_frame(0);
    join_none
    repeat (60) @(negedge clk_sys_i);
    check("bp_stall",    snk_stall_o,     1'b1);
    check("bp_accepted", accepted - a0,   9);
    check("bp_valid",    src_valid_o,     1'b1);
    rdy_force = 1'b1;
    #1;
    for (int t = 0; t < 2000 && send_busy; t++) @(negedge clk_sys_i);
    check("bp_done", send_busy, 1'b0);
    check_frame_results("bp", e0, p);
    drain("bp");

    // Randomized frames with random downstream ready
    rdy_rand = 1'b1;
    for (int f = 0; f < 40; f++) begin
      gen_random_frame();
      run_frame("rand", $urandom_range(0, 2));
    end
    drain("rand");

    // Reset in the middle of a frame
    rdy_rand  = 1'b0;
    rdy_force = 1'b0;
    @(posedge clk_sys_i); #1;
    snk_cyc_i = 1'b1;
    send_word(mk(2'b10, 2'b11, 16'h0400));
    send_word(mk(2'b00, 2'b11, 16'h0A0A));
    send_word(mk(2'b00, 2'b11, 16'h0B0B));
    send_word(mk(2'b00, 2'b11, 16'h0C0C));
    repeat (2) begin
      @(posedge clk_sys_i); #1;
    end
    rst_n_i   = 1'b1;
    snk_cyc_i = 1'b0;
    check_reset_outputs("midreset");
    @(posedge clk_sys_i); #1;
    rst_n_i = 1'b0;
    m_ok    = 16'h0000;
    m_err   = 16'h0000;
    m_class = 8'h00;
    rdy_rand = 1'b1;
    fr.delete();
    fr.push_back(mk(2'b10, 2'b11, 16'h0600));
    fr.push_back(mk(2'b00, 2'b11, 16'hD00D));
    fr.push_back(mk(2'b00, 2'b11, 16'hF00F));
    run_frame("postreset", 1);
    drain("postreset");

    repeat (3) @(negedge clk_sys_i);
    check("ack_total",      ack_cnt,  accepted);
    check("errpulse_total", err_seen, exp_err_pulses);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wrf_rx_sink.md
WRF_RX_SINK -- requirements
Module: wrf_rx_sink

Interface
REQ-001 SHALL have parameter g_fifo_depth, default 8, output FIFO depth in words (power of 2, >=4).
REQ-002 SHALL have ports, in this order:
  clk_sys_i  in  1  system clock
  rst_n_i  in  1  reset, asynchronous, active-high
  snk_cyc_i  in  1  fabric cycle (frame envelope)
  snk_stb_i  in  1  fabric strobe
  snk_adr_i  in  2  word type: 00 data, 01 OOB, 10 status, 11 user
  snk_dat_i  in  16  fabric word
  snk_sel_i  in  2  byte select; 11 full word, 10 upper byte only
  snk_ack_o  out  1  word acknowledge
  snk_stall_o  out  1  back-pressure
  snk_err_o  out  1  frame-order error pulse
  src_data_o  out  16  payload word
  src_sel_o  out  2  payload byte select
  src_sof_o  out  1  first word of frame
  src_eof_o  out  1  last word of frame
  src_err_o  out  1  frame flagged bad (valid with eof)
  src_valid_o  out  1  output word valid
  src_ready_i  in  1  downstream ready
  class_o  out  8  match class of current frame (status[15:8])
  frames_ok_o  out  16  good-frame counter
  frames_err_o  out  16  bad-frame counter

Function
REQ-003 SHALL accept a word when snk_cyc_i & snk_stb_i & ~snk_stall_o.
REQ-004 SHALL assert snk_ack_o exactly one cycle after each accepted word; never otherwise.
REQ-005 SHALL assert snk_stall_o when FIFO occupancy >= g_fifo_depth-1, reserving one slot for the hold-register flush.
REQ-006 SHALL implement states IDLE, HEADER, PAYLOAD.
REQ-007 IDLE -> HEADER on snk_cyc_i rising; any state -> IDLE one cycle after snk_cyc_i falls, once the flush of REQ-011 is done.
REQ-008 HEADER: status word (adr 10) SHALL latch class_o <= dat[15:8] and frame-bad <= dat[1], then go to PAYLOAD.
REQ-009 HEADER: data word before status SHALL pulse snk_err_o for 1 cycle, set frame-bad, set class_o = 0, go to PAYLOAD and treat the word as payload.
REQ-010 PAYLOAD: each data word SHALL enter a one-word hold register; the previous held word, if any, SHALL be pushed to the FIFO with eof=0.
REQ-011 On snk_cyc_i fall with a word held, the held word SHALL be pushed with eof=1 and err=frame-bad.
REQ-012 First pushed word of a frame SHALL carry sof=1.
REQ-013 OOB, user, and repeated status words SHALL be acked and discarded.
REQ-014 On frame end, frames_ok_o SHALL increment if the frame is not bad and has >=1 data word; otherwise frames_err_o SHALL increment.
REQ-015 Counters SHALL wrap 0xFFFF -> 0x0000.
REQ-016 A frame with zero data words SHALL push nothing to the FIFO.
REQ-017 FIFO output SHALL be first-word-fall-through: src_valid_o = non-empty; pop on src_valid_o & src_ready_i.
REQ-018 Simultaneous push and pop on a full or empty FIFO SHALL keep occupancy correct; no word lost or duplicated.
REQ-019 Latency from accepted data word to src_valid_o SHALL be 2 cycles after the next data word or cyc fall (hold register + FIFO write).
REQ-020 snk_cyc_i rising in the same cycle as the flush of REQ-011 SHALL start the new frame without losing the flush.

Reset
REQ-021 While rst_n_i=1, state SHALL be IDLE, the FIFO and hold register empty, and all outputs 0 (class_o=0x00, counters=0x0000).
REQ-022 Reset mid-frame SHALL discard the partial frame; the next frame starts cleanly after release.

Verification
REQ-023 Status 0x0300, 4 data words 0x1111..0x4444, src_ready_i=1 -> 4 outputs, sof on 0x1111, eof on 0x4444, class_o=0x03, frames_ok_o=1.
REQ-024 Status 0x0002 (error bit), 2 data words -> eof word has src_err_o=1, frames_err_o=1, frames_ok_o=0.
REQ-025 Data word with no preceding status -> snk_err_o pulses 1 cycle, class_o=0x00, frames_err_o=1.
REQ-026 src_ready_i=0, 20-word frame, depth 8 -> snk_stall_o asserts at occupancy 7; release ready -> all 20 words delivered in order, acks equal accepted words.
REQ-027 Status only, no data -> no FIFO output, frames_err_o=1.
REQ-028 rst_n_i pulsed after 3 words of a frame -> outputs 0; next 2-word frame delivered intact with sof/eof, frames_ok_o=1.
